// File: rtl/parking_time_tracker_if.sv
// parking_time_tracker_if: entry/exit event bus and stay-result outputs of the parking time tracker
interface parking_time_tracker_if #(
    parameter int TIME_W = 8,
    parameter int SLOTS  = 4,
    parameter int SLOT_W = 2
);
    logic              entry_valid;
    logic [SLOT_W-1:0] entry_slot;
    logic              exit_valid;
    logic [SLOT_W-1:0] exit_slot;
    logic [TIME_W-1:0] time_now;
    logic [SLOTS-1:0]  occupied;
    logic              done_valid;
    logic [SLOT_W-1:0] done_slot;
    logic [TIME_W-1:0] time_total;
    logic              err;
    modport master (
        output entry_valid, entry_slot, exit_valid, exit_slot,
        input  time_now, occupied, done_valid, done_slot, time_total, err
    );
    modport slave (
        input  entry_valid, entry_slot, exit_valid, exit_slot,
        output time_now, occupied, done_valid, done_slot, time_total, err
    );
endinterface

// File: rtl/parking_time_tracker.sv
// parking_time_tracker: prescaled timestamp base, per-slot entry stamps and wrap-safe stay durations
module parking_time_tracker #(
    parameter int TIME_W   = 8,
    parameter int SLOTS    = 4,
    parameter int SLOT_W   = 2,
    parameter int TICK_DIV = 16
) (
    input logic clk,
    input logic rst,
    parking_time_tracker_if.slave bus
);
    localparam int NS = 2 ** SLOT_W;
    localparam int PW = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;
    logic [PW-1:0]     pre;
    logic [TIME_W-1:0] tnow, tnxt, total;
    logic [TIME_W-1:0] stamp [NS];
    // sized to the full index space so out-of-range slot indices never select past the vector
    logic [NS-1:0]     occ, over;
    logic [SLOT_W-1:0] dslot;
    logic              tick, ex_ok, en_ok, dv, er;
    assign tick  = pre == PW'(TICK_DIV - 1);
    assign tnxt  = tnow + 1'b1;
    assign ex_ok = bus.exit_valid && 32'(bus.exit_slot) < SLOTS && occ[bus.exit_slot];
    // an occupied slot may be re-entered only when it is being vacated in the same cycle
    assign en_ok = bus.entry_valid && 32'(bus.entry_slot) < SLOTS &&
                   (!occ[bus.entry_slot] || (ex_ok && bus.exit_slot == bus.entry_slot));
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pre   <= '0;
            tnow  <= '0;
            occ   <= '0;
            over  <= '0;
            dv    <= 1'b0;
            er    <= 1'b0;
            dslot <= '0;
            total <= '0;
            for (int i = 0; i < NS; i++) stamp[i] <= '0;
        end else begin
            pre <= tick ? '0 : pre + 1'b1;
            if (tick) tnow <= tnxt;
            dv <= ex_ok;
            er <= (bus.entry_valid && !en_ok) || (bus.exit_valid && !ex_ok);
            // the counter is about to lap the entry stamp: the stay no longer fits in TIME_W
            for (int i = 0; i < SLOTS; i++)
                if (occ[i] && tick && tnxt == stamp[i]) over[i] <= 1'b1;
            if (ex_ok) begin
                total          <= over[bus.exit_slot] ? '1 : tnow - stamp[bus.exit_slot];
                dslot          <= bus.exit_slot;
                occ[bus.exit_slot] <= 1'b0;
            end
            if (en_ok) begin
                stamp[bus.entry_slot] <= tnow;
                occ[bus.entry_slot]   <= 1'b1;
                over[bus.entry_slot]  <= 1'b0;
            end
        end
    end
    assign bus.time_now   = tnow;
    assign bus.occupied   = occ[SLOTS-1:0];
    assign bus.done_valid = dv;
    assign bus.done_slot  = dslot;
    assign bus.time_total = total;
    assign bus.err        = er;
endmodule

// File: tb/tb_parking_time_tracker.sv
// tb_parking_time_tracker: directed checks of two tracker configurations (fast tick / slow tick with 3 slots)
module tb_parking_time_tracker;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int n_cmp = 0;
    int n_bad = 0;
    int tn;
    always #5 clk = ~clk;
    parking_time_tracker_if #(.TIME_W(8), .SLOTS(4), .SLOT_W(2)) ia ();
    parking_time_tracker_if #(.TIME_W(8), .SLOTS(3), .SLOT_W(2)) ib ();
    parking_time_tracker #(.TIME_W(8), .SLOTS(4), .SLOT_W(2), .TICK_DIV(1))  dut_a (.clk(clk), .rst(rst), .bus(ia));
    parking_time_tracker #(.TIME_W(8), .SLOTS(3), .SLOT_W(2), .TICK_DIV(16)) dut_b (.clk(clk), .rst(rst), .bus(ib));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_a(input logic [7:0] v);
        int n = 0;
        while (ia.time_now !== v && n < 600) begin
            step();
            n++;
        end
        if (n >= 600) chk("wait_time_now", 32'(ia.time_now), 32'(v));
    endtask

    task automatic ev_a(input logic en, input logic [1:0] es, input logic ex, input logic [1:0] xs);
        ia.entry_valid = en;
        ia.entry_slot  = es;
        ia.exit_valid  = ex;
        ia.exit_slot   = xs;
    endtask

    initial begin
        ev_a(0, 0, 0, 0);
        ib.entry_valid = 0; ib.entry_slot = 0; ib.exit_valid = 0; ib.exit_slot = 0;
        #1;
        chk("rst_time_now", 32'(ia.time_now), 0);
        chk("rst_occupied", 32'(ia.occupied), 0);
        chk("rst_done_valid", 32'(ia.done_valid), 0);
        chk("rst_time_total", 32'(ia.time_total), 0);
        chk("rst_err", 32'(ia.err), 0);
        step();
        rst = 1'b0;
        // slow tick, 3 slots: zero-length stay, out-of-range slot, prescaler boundary
        ib.entry_valid = 1; ib.entry_slot = 1;
        step();
        chk("b_occ_after_entry", 32'(ib.occupied), 32'b010);
        ib.entry_valid = 0; ib.exit_valid = 1; ib.exit_slot = 1;
        step();
        chk("b_zero_dv", 32'(ib.done_valid), 1);
        chk("b_zero_total", 32'(ib.time_total), 0);
        chk("b_zero_slot", 32'(ib.done_slot), 1);
        ib.exit_valid = 0; ib.entry_valid = 1; ib.entry_slot = 3;
        step();
        chk("b_range_err", 32'(ib.err), 1);
        chk("b_range_occ", 32'(ib.occupied), 0);
        chk("b_range_dv", 32'(ib.done_valid), 0);
        ib.entry_valid = 0;
        repeat (12) step();
        chk("b_time_before_tick", 32'(ib.time_now), 0);
        step();
        chk("b_time_after_tick", 32'(ib.time_now), 1);
        chk("b_err_cleared", 32'(ib.err), 0);
        // restart the fast tracker so its timestamp starts from 0 again
        rst = 1'b1;
        step();
        rst = 1'b0;
        // basic stay
        wait_a(1);
        ev_a(1, 0, 0, 0); step(); ev_a(0, 0, 0, 0);
        chk("basic_occ", 32'(ia.occupied), 32'b0001);
        wait_a(25);
        ev_a(0, 0, 1, 0); step(); ev_a(0, 0, 0, 0);
        chk("basic_dv", 32'(ia.done_valid), 1);
        chk("basic_slot", 32'(ia.done_slot), 0);
        chk("basic_total", 32'(ia.time_total), 24);
        chk("basic_occ_clr", 32'(ia.occupied), 0);
        step();
        chk("basic_dv_pulse", 32'(ia.done_valid), 0);
        chk("basic_total_hold", 32'(ia.time_total), 24);
        // wrap-around stays
        wait_a(250);
        ev_a(1, 2, 0, 0); step(); ev_a(0, 0, 0, 0);
        wait_a(3);
        ev_a(1, 1, 0, 0); step(); ev_a(0, 0, 0, 0);
        wait_a(4);
        ev_a(0, 0, 1, 2); step(); ev_a(0, 0, 0, 0);
        chk("wrap_total", 32'(ia.time_total), 10);
        chk("wrap_slot", 32'(ia.done_slot), 2);
        wait_a(80);
        ev_a(0, 0, 1, 1); step(); ev_a(0, 0, 0, 0);
        chk("wrap2_total", 32'(ia.time_total), 77);
        chk("wrap2_slot", 32'(ia.done_slot), 1);
        // overlong stay saturates, re-entry clears it
        wait_a(0);
        ev_a(1, 3, 0, 0); step(); ev_a(0, 0, 0, 0);
        repeat (300) step();
        ev_a(0, 0, 1, 3); step(); ev_a(0, 0, 0, 0);
        chk("overlong_total", 32'(ia.time_total), 255);
        chk("overlong_dv", 32'(ia.done_valid), 1);
        ev_a(1, 3, 0, 0); step(); ev_a(0, 0, 0, 0);
        repeat (4) step();
        ev_a(0, 0, 1, 3); step(); ev_a(0, 0, 0, 0);
        chk("reenter_total", 32'(ia.time_total), 5);
        // same-cycle exit and entry on occupied slot 1
        ev_a(1, 1, 0, 0); step(); ev_a(0, 0, 0, 0);
        repeat (6) step();
        ev_a(1, 1, 1, 1); step(); ev_a(0, 0, 0, 0);
        chk("swap_dv", 32'(ia.done_valid), 1);
        chk("swap_total", 32'(ia.time_total), 7);
        chk("swap_occ", 32'(ia.occupied), 32'b0010);
        chk("swap_err", 32'(ia.err), 0);
        step();
        chk("swap_single_pulse", 32'(ia.done_valid), 0);
        ev_a(0, 0, 1, 1); step(); ev_a(0, 0, 0, 0);
        chk("swap_restamp_total", 32'(ia.time_total), 2);
        // illegal events
        ev_a(0, 0, 1, 2); step(); ev_a(0, 0, 0, 0);
        chk("exit_free_err", 32'(ia.err), 1);
        chk("exit_free_dv", 32'(ia.done_valid), 0);
        step();
        chk("exit_free_err_pulse", 32'(ia.err), 0);
        ev_a(1, 0, 0, 0); step(); ev_a(0, 0, 0, 0);
        step();
        ev_a(1, 0, 0, 0); step(); ev_a(0, 0, 0, 0);
        chk("entry_occ_err", 32'(ia.err), 1);
        chk("entry_occ_occ", 32'(ia.occupied), 32'b0001);
        ev_a(0, 0, 1, 0); step(); ev_a(0, 0, 0, 0);
        chk("entry_occ_stamp_kept", 32'(ia.time_total), 3);
        chk("entry_occ_err_clr", 32'(ia.err), 0);
        ev_a(1, 2, 1, 2); step(); ev_a(0, 0, 0, 0);
        chk("same_free_err", 32'(ia.err), 1);
        chk("same_free_dv", 32'(ia.done_valid), 0);
        chk("same_free_occ", 32'(ia.occupied), 32'b0100);
        ev_a(0, 0, 1, 2); step(); ev_a(0, 0, 0, 0);
        // asynchronous reset mid-stay
        ev_a(1, 0, 0, 0); step();
        ev_a(1, 1, 0, 0); step(); ev_a(0, 0, 0, 0);
        chk("pre_rst_occ", 32'(ia.occupied), 32'b0011);
        ev_a(0, 0, 1, 1);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_time", 32'(ia.time_now), 0);
        chk("async_rst_occ", 32'(ia.occupied), 0);
        chk("async_rst_total", 32'(ia.time_total), 0);
        chk("async_rst_slot", 32'(ia.done_slot), 0);
        chk("async_rst_dv", 32'(ia.done_valid), 0);
        ev_a(0, 0, 0, 0);
        step();
        rst = 1'b0;
        ev_a(0, 0, 1, 0); step(); ev_a(0, 0, 0, 0);
        chk("post_rst_exit_err", 32'(ia.err), 1);
        chk("post_rst_exit_dv", 32'(ia.done_valid), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
